usb_dev_rw: RTL and testbench
=============================

Name: usb_dev_rw

Overview:
Device-side (thumb-drive) counterpart of the host read/write transaction FSM.
- Decodes incoming token packets (19 b) and data packets (72 b) from the device bit-level receiver.
- Tracks the two-phase transaction: a mempage OUT, then either a data OUT (write) or an IN (read).
- Drives a single-port page memory and returns ACK/NAK handshakes or a DATA0 packet with read data to the device transmitter.

Parameters:
DEV_ADDR, 7'b1010000, device address matched against token ADDR field
MAX_RETRY, 3, NAK'd IN data resends before the read is abandoned
TIMEOUT_CYCLES, 255, idle cycles before an expected packet is given up (TIMEOUT_EN only)

Ports:
clk  in  1  clock
rst_b  in  1  reset, synchronous, active-low
token_valid  in  1  1-cycle strobe, token_in valid
token_in  in  19  {PID[18:11], ADDR[10:4], ENDP[3:0]}
data_valid  in  1  1-cycle strobe, data_in valid
data_in  in  72  {PID[71:64], payload[63:0]}, payload bit-reversed (wire order)
hs_in_valid  in  1  1-cycle strobe, host handshake received
hs_in_pid  in  8  host handshake PID
data_out_ready  in  1  transmitter accepts data_pkt_out
hs_valid  out  1  1-cycle strobe, send handshake
hs_pid  out  8  ACK 8'b11010010 / NAK 8'b01011010
data_out_valid  out  1  data_pkt_out valid, held until ready
data_pkt_out  out  72  {8'b11000011, bit-reversed read data}
mem_addr  out  16  page address
mem_wdata  out  64  un-reversed write data
mem_we  out  1  1-cycle write strobe
mem_re  out  1  1-cycle read strobe; mem_rdata valid next cycle
mem_rdata  in  64  read data
xact_err  out  1  1-cycle strobe: read abandoned or timeout

Behaviour:
- Constants: OUT 8'b11100001, IN 8'b01101001, DATA0 8'b11000011, ENDP4 4'b0010, ENDP8 4'b0001.
- Reversal: rev(x)[i] = x[63-i]. Mempage = rev(payload)[15:0].
- Reset (rst_b low at posedge): state IDLE; page_valid=0; page=0; retry=0; every output 0.
- Tokens whose ADDR != DEV_ADDR, and unknown PIDs: ignored silently, no state change.
- IDLE:
  - OUT+ENDP4 -> RX_DATA.
  - IN+ENDP8 with page_valid=1 -> MEM_RD.
  - IN+ENDP8 with page_valid=0 -> NAK next cycle, stay IDLE.
  - data_valid in IDLE: ignored.
  - token_valid and data_valid together: token wins.
- RX_DATA:
  - data_valid with PID DATA0:
    - page_valid=0: page <= mempage, page_valid <= 1.
    - page_valid=1: mem_we pulse with mem_addr=page, mem_wdata=rev(payload); page_valid <= 0.
    - Both cases: ACK next cycle -> IDLE.
  - data_valid with other PID: NAK next cycle, page_valid unchanged -> IDLE.
  - token_valid in RX_DATA: ignored.
- MEM_RD: mem_re=1, mem_addr=page for one cycle -> LOAD.
- LOAD: register {DATA0, rev(mem_rdata)}, retry=0 -> TX_DATA.
- TX_DATA: data_out_valid=1, data_pkt_out stable until data_out_ready sampled high -> WAIT_HS.
- WAIT_HS:
  - ACK: page_valid <= 0 -> IDLE.
  - NAK, retry < MAX_RETRY: retry++ -> TX_DATA with the same registered packet; memory is not re-read.
  - NAK, retry == MAX_RETRY: xact_err pulse, page_valid <= 0 -> IDLE.
  - Other PID: ignored.
- Latency:
  - Data accept -> hs_valid: 1 cycle.
  - IN token -> data_out_valid: 3 cycles (MEM_RD, LOAD, TX_DATA).
- Reset mid-operation (any state): synchronous return to reset values next edge; a pending data_out_valid drops.

Optional Feature:
TIMEOUT_EN
- Defined:
  - 8-bit-or-wider counter runs in RX_DATA and WAIT_HS; it clears on entry and on every strobe.
  - Reaching TIMEOUT_CYCLES -> xact_err pulse, then IDLE.
  - RX_DATA timeout leaves page_valid unchanged; WAIT_HS timeout clears it.
- Undefined: no counter; both states wait indefinitely; xact_err is driven only by retry exhaustion.

Test Plan:
- Write: OUT/ADDR/ENDP4 token, DATA0 with rev(0x...0042) -> ACK. OUT token again, DATA0 with rev(0xDEADBEEFCAFEF00D) -> mem_we=1, mem_addr=0x0042, mem_wdata=0xDEADBEEFCAFEF00D, ACK, page_valid=0.
- Read: page 0x0010 phase, IN/ENDP8, mem_rdata=0x0123456789ABCDEF -> mem_re 1 cycle after token; data_out_valid 3 cycles after token; data_pkt_out={8'hC3, rev(0x0123456789ABCDEF)}. Host ACK -> IDLE.
- Retry: read with host NAK ×3 then ACK -> 4 identical data_out transfers, xact_err=0. NAK ×4 -> xact_err pulse after 4th NAK, next IN gets NAK.
- Negatives:
  - IN before any page -> NAK.
  - Token with ADDR 7'b0000001 -> no hs_valid.
  - DATA PID 8'h4B in RX_DATA -> NAK, page_valid unchanged.
- Simultaneous token+data in IDLE -> token processed, data dropped. Reset asserted in TX_DATA -> data_out_valid=0 next cycle, page_valid=0.
- TIMEOUT_EN, TIMEOUT_CYCLES=8: OUT token then silence -> xact_err at 8th cycle, then IDLE. Without the macro, same stimulus stays in RX_DATA forever.

Source files
------------

// File: rtl/usb_dev_rw.sv
// usb_dev_rw: device-side read/write transaction FSM.
// Optional macro TIMEOUT_EN adds an idle timeout in RX_DATA and WAIT_HS.
module usb_dev_rw #(
  parameter logic [6:0] DEV_ADDR = 7'b1010000,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        token_valid,
  input  logic [18:0] token_in,
  input  logic        data_valid,
  input  logic [71:0] data_in,
  input  logic        hs_in_valid,
  input  logic [7:0]  hs_in_pid,
  input  logic        data_out_ready,
  output logic        hs_valid,
  output logic [7:0]  hs_pid,
  output logic        data_out_valid,
  output logic [71:0] data_pkt_out,
  output logic [15:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [63:0] mem_rdata,
  output logic        xact_err
);

  localparam logic [7:0] PID_OUT   = 8'b11100001;
  localparam logic [7:0] PID_IN    = 8'b01101001;
  localparam logic [7:0] PID_DATA0 = 8'b11000011;
  localparam logic [7:0] PID_ACK   = 8'b11010010;
  localparam logic [7:0] PID_NAK   = 8'b01011010;
  localparam logic [3:0] ENDP4     = 4'b0010;
  localparam logic [3:0] ENDP8     = 4'b0001;
  localparam logic [7:0] RMAX      = 8'(MAX_RETRY);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX_DATA = 3'd1;
  localparam logic [2:0] S_MEM_RD  = 3'd2;
  localparam logic [2:0] S_LOAD    = 3'd3;
  localparam logic [2:0] S_TX_DATA = 3'd4;
  localparam logic [2:0] S_WAIT_HS = 3'd5;

  function automatic logic [63:0] rev64(input logic [63:0] x);
    for (int i = 0; i < 64; i++) rev64[i] = x[63-i];
  endfunction

  logic [2:0]  state;
  logic        page_valid;
  logic [15:0] page;
  logic [7:0]  retry;

  logic [63:0] rev_pl;
  logic [63:0] rev_rd;
  logic        tok_hit;
  logic        out_tok;
  logic        in_tok;

  assign rev_pl  = rev64(data_in[63:0]);
  assign rev_rd  = rev64(mem_rdata);
  assign tok_hit = token_valid &&
                   (token_in[10:4] == DEV_ADDR);
  assign out_tok = tok_hit &&
                   (token_in[18:11] == PID_OUT) &&
                   (token_in[3:0] == ENDP4);
  assign in_tok  = tok_hit &&
                   (token_in[18:11] == PID_IN) &&
                   (token_in[3:0] == ENDP8);

`ifdef TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        tmo_strobe;
  logic        tmo_fire;
  logic        tmo_run;

  assign tmo_strobe = token_valid | data_valid |
                      hs_in_valid;
  assign tmo_run    = (state == S_RX_DATA) ||
                      (state == S_WAIT_HS);
  assign tmo_fire   = tmo_run && !tmo_strobe &&
    (tmo_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_b) tmo_cnt <= '0;
    else if (tmo_run && !tmo_strobe)
      tmo_cnt <= tmo_cnt + 16'd1;
    else tmo_cnt <= '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state          <= S_IDLE;
      page_valid     <= 1'b0;
      page           <= '0;
      retry          <= '0;
      hs_valid       <= 1'b0;
      hs_pid         <= '0;
      data_out_valid <= 1'b0;
      data_pkt_out   <= '0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      mem_we         <= 1'b0;
      mem_re         <= 1'b0;
      xact_err       <= 1'b0;
    end else begin
      hs_valid <= 1'b0;
      mem_we   <= 1'b0;
      mem_re   <= 1'b0;
      xact_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (out_tok) begin
            state <= S_RX_DATA;
          end else if (in_tok) begin
            if (page_valid) begin
              mem_re   <= 1'b1;
              mem_addr <= page;
              state    <= S_MEM_RD;
            end else begin
              hs_valid <= 1'b1;
              hs_pid   <= PID_NAK;
            end
          end
        end
        S_RX_DATA: begin
          if (data_valid) begin
            hs_valid <= 1'b1;
            state    <= S_IDLE;
            if (data_in[71:64] == PID_DATA0) begin
              hs_pid <= PID_ACK;
              if (!page_valid) begin
                page       <= rev_pl[15:0];
                page_valid <= 1'b1;
              end else begin
                mem_we     <= 1'b1;
                mem_addr   <= page;
                mem_wdata  <= rev_pl;
                page_valid <= 1'b0;
              end
            end else begin
              hs_pid <= PID_NAK;
            end
          end
`ifdef TIMEOUT_EN
          else if (tmo_fire) begin
            xact_err <= 1'b1;
            state    <= S_IDLE;
          end
`endif
        end
        S_MEM_RD: state <= S_LOAD;
        S_LOAD: begin
          data_pkt_out   <= {PID_DATA0, rev_rd};
          retry          <= '0;
          data_out_valid <= 1'b1;
          state          <= S_TX_DATA;
        end
        S_TX_DATA: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            state          <= S_WAIT_HS;
          end
        end
        S_WAIT_HS: begin
          if (hs_in_valid && hs_in_pid == PID_ACK) begin
            page_valid <= 1'b0;
            state      <= S_IDLE;
          end else if (hs_in_valid &&
                       hs_in_pid == PID_NAK) begin
            if (retry < RMAX) begin
              retry          <= retry + 8'd1;
              data_out_valid <= 1'b1;
              state          <= S_TX_DATA;
            end else begin
              xact_err   <= 1'b1;
              page_valid <= 1'b0;
              state      <= S_IDLE;
            end
          end
`ifdef TIMEOUT_EN
          else if (tmo_fire) begin
            xact_err   <= 1'b1;
            page_valid <= 1'b0;
            state      <= S_IDLE;
          end
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_dev_rw.sv
// tb_usb_dev_rw: table-driven directed checks for usb_dev_rw
// plus reset-in-flight and timeout sequences.
module tb_usb_dev_rw;

  localparam logic [7:0]  OUT = 8'hE1;
  localparam logic [7:0]  IN  = 8'h69;
  localparam logic [7:0]  D0  = 8'hC3;
  localparam logic [7:0]  ACK = 8'hD2;
  localparam logic [7:0]  NAK = 8'h5A;
  localparam logic [3:0]  E4  = 4'h2;
  localparam logic [3:0]  E8  = 4'h1;
  localparam logic [6:0]  DEV = 7'h50;
  localparam logic [63:0] RD  = 64'h0123456789ABCDEF;

  typedef struct packed {
    logic        tv;
    logic [18:0] tok;
    logic        dv;
    logic [71:0] din;
    logic        hv;
    logic [7:0]  hpid;
    logic        rdy;
  } in_t;

  typedef struct packed {
    logic        hs;
    logic [7:0]  hpid;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [63:0] wdata;
    logic        dov;
    logic [71:0] pkt;
    logic        err;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        token_valid;
  logic [18:0] token_in;
  logic        data_valid;
  logic [71:0] data_in;
  logic        hs_in_valid;
  logic [7:0]  hs_in_pid;
  logic        data_out_ready;
  logic        hs_valid;
  logic [7:0]  hs_pid;
  logic        data_out_valid;
  logic [71:0] data_pkt_out;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [63:0] mem_rdata;
  logic        xact_err;

  int nchk = 0;
  int nfail = 0;
  logic [71:0] pkt_e;
  vec_t tbl[$];

  always #5 clk = ~clk;

  usb_dev_rw #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .token_valid(token_valid), .token_in(token_in),
    .data_valid(data_valid), .data_in(data_in),
    .hs_in_valid(hs_in_valid), .hs_in_pid(hs_in_pid),
    .data_out_ready(data_out_ready),
    .hs_valid(hs_valid), .hs_pid(hs_pid),
    .data_out_valid(data_out_valid),
    .data_pkt_out(data_pkt_out),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .xact_err(xact_err)
  );

  function automatic logic [63:0] rev(input logic [63:0] x);
    logic [63:0] r;
    for (int k = 0; k < 64; k++) r[63-k] = x[k];
    return r;
  endfunction

  function automatic in_t nil();
    in_t r = '0;
    return r;
  endfunction
  function automatic in_t tk(input logic [7:0] p,
                             input logic [6:0] a,
                             input logic [3:0] e);
    in_t r = '0;
    r.tv = 1'b1;
    r.tok = {p, a, e};
    return r;
  endfunction
  function automatic in_t dt(input logic [7:0] p,
                             input logic [63:0] pl);
    in_t r = '0;
    r.dv = 1'b1;
    r.din = {p, pl};
    return r;
  endfunction
  function automatic in_t hk(input logic [7:0] p);
    in_t r = '0;
    r.hv = 1'b1;
    r.hpid = p;
    return r;
  endfunction
  function automatic in_t rdy();
    in_t r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic out_t none();
    out_t r = '0;
    return r;
  endfunction
  function automatic out_t hs(input logic [7:0] p);
    out_t r = '0;
    r.hs = 1'b1;
    r.hpid = p;
    return r;
  endfunction
  function automatic out_t wr(input logic [15:0] a,
                              input logic [63:0] w);
    out_t r = hs(ACK);
    r.we = 1'b1;
    r.addr = a;
    r.wdata = w;
    return r;
  endfunction
  function automatic out_t rd(input logic [15:0] a);
    out_t r = '0;
    r.re = 1'b1;
    r.addr = a;
    return r;
  endfunction
  function automatic out_t dov();
    out_t r = '0;
    r.dov = 1'b1;
    r.pkt = pkt_e;
    return r;
  endfunction
  function automatic out_t err();
    out_t r = '0;
    r.err = 1'b1;
    return r;
  endfunction

  function automatic out_t mask(input out_t e);
    out_t m = '1;
    if (!e.hs) m.hpid = '0;
    if (!(e.we || e.re)) m.addr = '0;
    if (!e.we) m.wdata = '0;
    if (!e.dov) m.pkt = '0;
    return m;
  endfunction

  task automatic add(input in_t i, input out_t o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t i);
    token_valid    = i.tv;
    token_in       = i.tok;
    data_valid     = i.dv;
    data_in        = i.din;
    hs_in_valid    = i.hv;
    hs_in_pid      = i.hpid;
    data_out_ready = i.rdy;
  endtask

  task automatic check(input out_t e, input out_t m,
                       input string tag);
    out_t a;
    a.hs    = hs_valid;
    a.hpid  = hs_pid;
    a.we    = mem_we;
    a.re    = mem_re;
    a.addr  = mem_addr;
    a.wdata = mem_wdata;
    a.dov   = data_out_valid;
    a.pkt   = data_pkt_out;
    a.err   = xact_err;
    nchk++;
    if ((a & m) != (e & m)) begin
      nfail++;
      $display("FAIL %s: got %h expected %h",
               tag, a & m, e & m);
    end
  endtask

  task automatic step(input in_t i, input out_t e,
                      input string tag);
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1;
    check(e, mask(e), tag);
  endtask

  initial begin
    in_t s;
    pkt_e = {D0, rev(RD)};
    mem_rdata = RD;
    rst_b = 1'b0;
    drive(nil());

    add(nil(), none());
    add(tk(IN, DEV, E8), hs(NAK));
    add(tk(OUT, 7'h01, E4), none());
    add(dt(D0, rev(64'h42)), none());
    add(tk(8'hA5, DEV, E4), none());
    add(dt(D0, rev(64'h42)), none());
    add(tk(OUT, DEV, E4), none());
    add(tk(IN, DEV, E8), none());
    add(dt(D0, rev(64'h42)), hs(ACK));
    add(tk(OUT, DEV, E4), none());
    add(dt(8'h4B, rev(64'h99)), hs(NAK));
    add(tk(OUT, DEV, E4), none());
    add(dt(D0, rev(64'hDEADBEEFCAFEF00D)),
        wr(16'h0042, 64'hDEADBEEFCAFEF00D));
    add(tk(IN, DEV, E8), hs(NAK));
    add(tk(OUT, DEV, E4), none());
    add(dt(D0, rev(64'h10)), hs(ACK));
    add(tk(IN, DEV, E8), rd(16'h0010));
    add(nil(), none());
    add(nil(), dov());
    add(nil(), dov());
    add(rdy(), none());
    add(hk(ACK), none());
    add(tk(IN, DEV, E8), hs(NAK));
    s = tk(OUT, DEV, E4);
    s.dv = 1'b1;
    s.din = {D0, rev(64'h20)};
    add(s, none());
    add(dt(D0, rev(64'h30)), hs(ACK));
    add(tk(IN, DEV, E8), rd(16'h0030));
    add(nil(), none());
    add(nil(), dov());
    for (int k = 0; k < 3; k++) begin
      add(rdy(), none());
      add(hk(NAK), dov());
    end
    add(rdy(), none());
    add(hk(D0), none());
    add(hk(ACK), none());
    add(tk(IN, DEV, E8), hs(NAK));
    add(tk(OUT, DEV, E4), none());
    add(dt(D0, rev(64'h40)), hs(ACK));
    add(tk(IN, DEV, E8), rd(16'h0040));
    add(nil(), none());
    add(nil(), dov());
    for (int k = 0; k < 4; k++) begin
      add(rdy(), none());
      add(hk(NAK), (k < 3) ? dov() : err());
    end
    add(tk(IN, DEV, E8), hs(NAK));

    repeat (2) @(posedge clk);
    #1;
    check(none(), '1, "reset");
    @(negedge clk);
    rst_b = 1'b1;

    foreach (tbl[k])
      step(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));

    step(tk(OUT, DEV, E4), none(), "rst_out");
    step(dt(D0, rev(64'h50)), hs(ACK), "rst_page");
    step(tk(IN, DEV, E8), rd(16'h0050), "rst_in");
    step(nil(), none(), "rst_load");
    step(nil(), dov(), "rst_tx");
    @(negedge clk);
    drive(nil());
    rst_b = 1'b0;
    @(posedge clk);
    #1;
    check(none(), '1, "rst_mid");
    @(negedge clk);
    rst_b = 1'b1;
    step(tk(IN, DEV, E8), hs(NAK), "rst_pv");

    step(tk(OUT, DEV, E4), none(), "tmo_out");
    for (int k = 1; k <= 10; k++) begin
`ifdef TIMEOUT_EN
      step(nil(), (k == 8) ? err() : none(),
           $sformatf("tmo_wait%0d", k));
`else
      step(nil(), none(), $sformatf("tmo_wait%0d", k));
`endif
    end
`ifdef TIMEOUT_EN
    step(dt(D0, rev(64'h60)), none(), "tmo_idle");
`else
    step(dt(D0, rev(64'h60)), hs(ACK), "tmo_still_rx");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
